instr_ctrl_fsm: RTL and testbench

- Multi-cycle instruction sequencer placed directly upstream of the register-bank/ALU datapath.
- Accepts one 16-bit instruction word through a valid/ready handshake and decodes it.
- Drives the datapath controls: wEnable, opcode, Rdest_select, Rsrc_select, Imm_select, Imm_in.
- Pulses a one-hot register write enable so the ALU result is written back to Rdest.

---
 rtl/instr_ctrl_fsm_if.sv | 23 ++
 rtl/instr_ctrl_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_instr_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_ctrl_fsm_if.sv
// Instruction handshake bundle between the upstream instruction source and
// the sequencer.
//   instr_in    : 16-bit instruction word
//   instr_valid : instr_in is valid this cycle (source holds it until accepted)
//   instr_ready : sequencer can accept an instruction
// master = instruction source, slave = sequencer.
interface instr_ctrl_fsm_if;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr_in,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_in,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/instr_ctrl_fsm.sv
// Multi-cycle instruction sequencer feeding the register-bank/ALU datapath.
// Accepts one instruction word per handshake, decodes it, drives the datapath
// selects and pulses a one-hot register write enable in the writeback cycle.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   bus (slave)   : instr_in / instr_valid / instr_ready handshake
//   wEnable       : one-hot register write enable, only during WB
//   opcode        : ALU opcode
//   Rdest_select  : destination register select
//   Rsrc_select   : source register select
//   Imm_select    : 1 selects Imm_in instead of Rsrc
//   Imm_in        : extended immediate
//   done          : one-cycle pulse when an instruction retires
//   illegal       : one-cycle pulse when an undecodable word is dropped
//   retired_cnt   : retired-instruction counter (wraps)
module instr_ctrl_fsm #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_ctrl_fsm_if.slave     bus,
  output logic [NUM_REGS-1:0] wEnable,
  output logic [7:0]          opcode,
  output logic [3:0]          Rdest_select,
  output logic [3:0]          Rsrc_select,
  output logic                Imm_select,
  output logic [15:0]         Imm_in,
  output logic                done,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_REG    = 2'd0,
    CLS_IMM_ZX = 2'd1,
    CLS_IMM_SX = 2'd2,
    CLS_ILL    = 2'd3
  } cls_t;

  // Instruction class from the op field
  function automatic cls_t f_classify(input logic [3:0] op);
    cls_t cls;
    case (op)
      4'h0:                   cls = CLS_REG;
      4'h1, 4'h2, 4'h3, 4'hD: cls = CLS_IMM_ZX;
      4'h5, 4'h9, 4'hB:       cls = CLS_IMM_SX;
      default:                cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_ready;
  logic [NUM_REGS-1:0]  r_wen;
  logic [7:0]           r_opcode;
  logic [3:0]           r_rdest;
  logic [3:0]           r_rsrc;
  logic                 r_imm_sel;
  logic [15:0]          r_imm;
  logic                 r_done;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_cnt;

  logic [INSTR_W-1:0]   w_instr_d;
  logic                 w_ready_d;
  logic [NUM_REGS-1:0]  w_wen_d;
  logic [7:0]           w_opcode_d;
  logic [3:0]           w_rdest_d;
  logic [3:0]           w_rsrc_d;
  logic                 w_imm_sel_d;
  logic [15:0]          w_imm_d;
  logic                 w_done_d;
  logic                 w_illegal_d;
  logic [CNT_W-1:0]     w_cnt_d;

  cls_t                 w_cls_in;
  cls_t                 w_cls_lat;
  logic                 w_is_cmp;

  assign w_cls_in  = f_classify(bus.instr_in[15:12]);
  assign w_cls_lat = f_classify(r_instr[15:12]);
  // Compares retire but never write back
  assign w_is_cmp  = ((r_instr[15:12] == 4'h0) && (r_instr[7:4] == 4'hB)) ||
                     (r_instr[15:12] == 4'hB);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; instr_ready is 1 exactly when in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.instr_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_cls_lat == CLS_ILL) ? S_IDLE : S_EXEC;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; decode outputs hold unless rewritten
  always_comb begin
    w_instr_d   = r_instr;
    w_ready_d   = (w_state_nxt == S_IDLE);
    w_wen_d     = '0;
    w_opcode_d  = r_opcode;
    w_rdest_d   = r_rdest;
    w_rsrc_d    = r_rsrc;
    w_imm_sel_d = r_imm_sel;
    w_imm_d     = r_imm;
    w_done_d    = 1'b0;
    w_illegal_d = 1'b0;
    w_cnt_d     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          w_instr_d = bus.instr_in;
          // Registered here so the pulse is visible during the DECODE cycle
          w_illegal_d = (w_cls_in == CLS_ILL);
        end
      end
      S_DECODE: begin
        w_rdest_d = r_instr[11:8];
        case (w_cls_lat)
          CLS_REG: begin
            w_opcode_d  = {4'b0000, r_instr[7:4]};
            w_imm_sel_d = 1'b0;
            w_rsrc_d    = r_instr[3:0];
          end
          CLS_IMM_ZX: begin
            w_opcode_d  = {r_instr[15:12], 4'b0000};
            w_imm_sel_d = 1'b1;
            w_imm_d     = {8'h00, r_instr[7:0]};
          end
          CLS_IMM_SX: begin
            w_opcode_d  = {r_instr[15:12], 4'b0000};
            w_imm_sel_d = 1'b1;
            w_imm_d     = {{8{r_instr[7]}}, r_instr[7:0]};
          end
          default: w_rdest_d = r_rdest;
        endcase
      end
      S_EXEC: begin
        // Loaded leaving EXEC so wEnable/done are high during WB only
        w_wen_d  = w_is_cmp ? '0 : (NUM_REGS'(1) << r_instr[11:8]);
        w_done_d = 1'b1;
        w_cnt_d  = r_cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr   <= '0;
      r_ready   <= 1'b1;
      r_wen     <= '0;
      r_opcode  <= '0;
      r_rdest   <= '0;
      r_rsrc    <= '0;
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_instr   <= w_instr_d;
      r_ready   <= w_ready_d;
      r_wen     <= w_wen_d;
      r_opcode  <= w_opcode_d;
      r_rdest   <= w_rdest_d;
      r_rsrc    <= w_rsrc_d;
      r_imm_sel <= w_imm_sel_d;
      r_imm     <= w_imm_d;
      r_done    <= w_done_d;
      r_illegal <= w_illegal_d;
      r_cnt     <= w_cnt_d;
    end
  end

  assign bus.instr_ready = r_ready;
  assign wEnable         = r_wen;
  assign opcode          = r_opcode;
  assign Rdest_select    = r_rdest;
  assign Rsrc_select     = r_rsrc;
  assign Imm_select      = r_imm_sel;
  assign Imm_in          = r_imm;
  assign done            = r_done;
  assign illegal         = r_illegal;
  assign retired_cnt     = r_cnt;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Scoreboard bench for instr_ctrl_fsm. A driver issues directed and random
// instructions; accepted words are turned into expected responses by a
// reference model and queued; a monitor on the falling edge compares.
// A second instance with a 4-bit counter shares the same stimulus so the
// counter wrap is reached within a short run.
`timescale 1ns/1ps
module tb_instr_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_ctrl_fsm_if bus ();
  instr_ctrl_fsm_if bus_w ();
  assign bus_w.instr_in    = bus.instr_in;
  assign bus_w.instr_valid = bus.instr_valid;

  logic [15:0] wEnable, Imm_in;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select, Rsrc_select;
  logic        Imm_select, done, illegal;
  logic [15:0] retired_cnt;

  logic [15:0] wEnable_w, Imm_in_w;
  logic [7:0]  opcode_w;
  logic [3:0]  Rdest_select_w, Rsrc_select_w;
  logic        Imm_select_w, done_w, illegal_w;
  logic [3:0]  retired_cnt_w;

  instr_ctrl_fsm #(.NUM_REGS(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .wEnable(wEnable), .opcode(opcode), .Rdest_select(Rdest_select),
    .Rsrc_select(Rsrc_select), .Imm_select(Imm_select), .Imm_in(Imm_in),
    .done(done), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  instr_ctrl_fsm #(.NUM_REGS(16), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w),
    .wEnable(wEnable_w), .opcode(opcode_w), .Rdest_select(Rdest_select_w),
    .Rsrc_select(Rsrc_select_w), .Imm_select(Imm_select_w), .Imm_in(Imm_in_w),
    .done(done_w), .illegal(illegal_w), .retired_cnt(retired_cnt_w)
  );

  typedef struct {
    bit          ill;
    bit          regf;
    logic [7:0]  opc;
    bit          imm_sel;
    logic [15:0] imm;
    logic [3:0]  rsrc;
    logic [3:0]  rdest;
    logic [15:0] wen;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   free_at = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected response of one accepted word, accepted at edge acc
  function automatic exp_t model(input logic [15:0] w, input int acc);
    exp_t e;
    int op, ext, rd, imm;
    op  = int'(w[15:12]);
    ext = int'(w[7:4]);
    rd  = int'(w[11:8]);
    imm = int'(w[7:0]);
    e.acc = acc; e.ill = 0; e.regf = 0; e.imm_sel = 0; e.imm = '0;
    e.rsrc = w[3:0]; e.rdest = w[11:8];
    e.opc = 8'(op * 16);
    if (op == 0) begin
      e.regf = 1;
      e.opc  = 8'(ext);
    end else if (op == 1 || op == 2 || op == 3 || op == 13) begin
      e.imm_sel = 1;
      e.imm     = 16'(imm);
    end else if (op == 5 || op == 9 || op == 11) begin
      e.imm_sel = 1;
      if (imm >= 128) imm = imm - 256;
      e.imm = 16'(imm);
    end else begin
      e.ill = 1;
    end
    e.wen = (op == 11 || (op == 0 && ext == 11)) ? 16'h0000 : 16'(2 ** rd);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_wen", 32'(wEnable), 32'd0);
      chk("rst_pulses", 32'({done, illegal}), 32'd0);
      chk("rst_cnt", 32'(retired_cnt), 32'd0);
      chk("rst_cnt_w", 32'(retired_cnt_w), 32'd0);
    end else begin
      chk("ready", 32'(bus.instr_ready), 32'(cyc >= free_at));
      if (done || illegal) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pulse: got done=%0b illegal=%0b expected none (cycle %0d)",
                   done, illegal, cyc);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", 32'({done, illegal}), e.ill ? 32'd1 : 32'd2);
          chk("pulse_cycle", 32'(cyc), e.ill ? 32'(e.acc) : 32'(e.acc + 2));
          if (!e.ill) begin
            model_cnt = (model_cnt + 1) % 65536;
            chk("wb_wen", 32'(wEnable), 32'(e.wen));
            chk("wb_opcode", 32'(opcode), 32'(e.opc));
            chk("wb_rdest", 32'(Rdest_select), 32'(e.rdest));
            chk("retired_cnt", 32'(retired_cnt), 32'(model_cnt));
            chk("retired_cnt_w", 32'(retired_cnt_w), 32'(model_cnt % 16));
          end else begin
            chk("ill_wen", 32'(wEnable), 32'd0);
          end
        end
      end else begin
        chk("idle_wen", 32'(wEnable), 32'd0);
      end
      // Decode outputs must be valid in EXEC
      if (q.size() > 0 && !q[0].ill && cyc == q[0].acc + 1) begin
        chk("ex_opcode", 32'(opcode), 32'(q[0].opc));
        chk("ex_imm_sel", 32'(Imm_select), 32'(q[0].imm_sel));
        chk("ex_rdest", 32'(Rdest_select), 32'(q[0].rdest));
        if (q[0].regf) chk("ex_rsrc", 32'(Rsrc_select), 32'(q[0].rsrc));
        else           chk("ex_imm", 32'(Imm_in), 32'(q[0].imm));
      end
      // Expected response overdue
      if (q.size() > 0 && cyc > q[0].acc + (q[0].ill ? 0 : 2)) begin
        e = q.pop_front();
        n_vec++; n_err++;
        $display("FAIL missing_response: got none expected response for edge %0d (cycle %0d)",
                 e.acc, cyc);
      end
      // Handshake completes at the next rising edge
      if (bus.instr_valid && bus.instr_ready) begin
        e = model(bus.instr_in, cyc + 1);
        q.push_back(e);
        free_at = e.ill ? cyc + 2 : cyc + 4;
      end
    end
  end

  task automatic send(input logic [15:0] w, input bit drop);
    bit ok;
    ok = 0;
    bus.instr_in    = w;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (bus.instr_ready) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept of %h (cycle %0d)", w, cyc);
    end
    if (drop) bus.instr_valid = 1'b0;
  endtask

  logic [15:0] directed [5];

  initial begin
    directed[0] = 16'h0352;
    directed[1] = 16'h94FF;
    directed[2] = 16'h1780;
    directed[3] = 16'hB205;
    directed[4] = 16'hE000;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed words from the test plan, one at a time
    for (int i = 0; i < 5; i++) begin
      send(directed[i], 1'b1);
      repeat (5) @(posedge clk);
      #1;
    end

    // Back-to-back: valid held high, next word presented right after each accept
    for (int i = 0; i < 60; i++) send(16'($urandom), 1'b0);
    bus.instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Reset asserted while the instruction sits in EXEC
    send(16'h0352, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    free_at   = 0;
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Random traffic with random idle gaps
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(16'($urandom), 1'b1);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
